// File: rtl/x_exec_wb_pkg.sv
// Shared constants for the X-form execute/writeback stage.
//   PO_X      : primary opcode that selects the X-form decode
//   XO_*      : 9-bit extended opcodes handled by the stage
//   StIdle/St*: FSM state encodings
//   CR0_*     : bit positions inside the 4-bit CR0 field {LT,GT,EQ,SO}
//   cr0_of()  : derives the CR0 field from a result and the sampled SO bit
package x_exec_pkg;

  localparam logic [5:0] PO_X = 6'd31;

  localparam logic [8:0] XO_AND    = 9'd28;
  localparam logic [8:0] XO_CNTLZD = 9'd58;
  localparam logic [8:0] XO_ANDC   = 9'd60;
  localparam logic [8:0] XO_NOR    = 9'd124;
  localparam logic [8:0] XO_EQV    = 9'd284;
  localparam logic [8:0] XO_XOR    = 9'd316;
  localparam logic [8:0] XO_EXTSH  = 9'd410;
  localparam logic [8:0] XO_ORC    = 9'd412;
  localparam logic [8:0] XO_EXTSB  = 9'd442;
  localparam logic [8:0] XO_OR     = 9'd444;
  localparam logic [8:0] XO_EXTSW  = 9'd474;
  localparam logic [8:0] XO_NAND   = 9'd476;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StCnt  = 1'b1;

  localparam int unsigned CR0_LT = 3;
  localparam int unsigned CR0_GT = 2;
  localparam int unsigned CR0_EQ = 1;
  localparam int unsigned CR0_SO = 0;

  function automatic logic [3:0] cr0_of(input logic [63:0] res, input logic so);
    logic [3:0] f;
    f         = '0;
    f[CR0_LT] = res[63];
    f[CR0_GT] = ~res[63] & (|res);
    f[CR0_EQ] = ~(|res);
    f[CR0_SO] = so;
    return f;
  endfunction

endpackage

// File: rtl/x_exec_wb_if.sv
// Bus between the X-form register-read stage (master) and the execute/writeback
// stage (slave).
//   in_valid/in_ready        : issue handshake
//   po/xo/rc/ra              : decoded instruction fields
//   datars/datarb/xer_so     : operands and XER[SO]
//   wb_en/wb_addr/wb_data    : register-file write port for RA
//   cr0_we/cr0               : CR0 write port {LT,GT,EQ,SO}
//   illegal/busy             : status
interface x_exec_wb_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      po;
  logic [8:0]      xo;
  logic            rc;
  logic [4:0]      ra;
  logic [XLEN-1:0] datars;
  logic [XLEN-1:0] datarb;
  logic            xer_so;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            cr0_we;
  logic [3:0]      cr0;
  logic            illegal;
  logic            busy;

  modport master (
    output in_valid, po, xo, rc, ra, datars, datarb, xer_so,
    input  in_ready, wb_en, wb_addr, wb_data, cr0_we, cr0, illegal, busy
  );

  modport slave (
    input  in_valid, po, xo, rc, ra, datars, datarb, xer_so,
    output in_ready, wb_en, wb_addr, wb_data, cr0_we, cr0, illegal, busy
  );
endinterface

// File: rtl/x_exec_wb_lzc16.sv
// Combinational 16-bit leading-zero counter.
//   data_i : 16-bit value
//   cnt_o  : number of leading zeros, 16 when data_i is zero
module lzc16 (
  input  logic [15:0] data_i,
  output logic [4:0]  cnt_o
);

  // Scanning upward lets the highest set bit overwrite any lower one.
  always_comb begin
    cnt_o = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (data_i[i]) cnt_o = 5'(15 - i);
    end
  end

endmodule

// File: rtl/x_exec_wb.sv
// X-form execute/writeback stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of x_exec_wb_if (issue handshake, operands,
//                register-file and CR0 write ports, illegal/busy status)
// Logical and extend ops write back one cycle after accept. cntlzd occupies the
// stage for four cycles, examining one 16-bit chunk per cycle (MSB chunk at the
// accept edge) with a single shared lzc16; the writeback lands in the last busy
// cycle.
module x_exec_wb #(
  parameter int unsigned XLEN = 64,
  parameter logic [5:0]  PO_X = x_exec_pkg::PO_X
) (
  input logic        clk,
  input logic        rst_n,
  x_exec_wb_if.slave bus
);
  import x_exec_pkg::*;

  logic [0:0]      state_q, state_d;
  logic [1:0]      k_q, k_d;
  logic [XLEN-1:0] rs_q, rs_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            found_q, found_d;
  logic [4:0]      ra_q, ra_d;
  logic            rc_q, rc_d;
  logic            so_q, so_d;

  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            cr0_we_q, cr0_we_d;
  logic [3:0]      cr0_q, cr0_d;
  logic            illegal_q, illegal_d;

  logic            in_ready;
  logic            accept;
  logic            op_legal;
  logic            op_cnt;
  logic [XLEN-1:0] op_res;
  logic [XLEN-1:0] rs;
  logic [XLEN-1:0] rb;

  assign in_ready = (state_q == StIdle);
  assign accept   = bus.in_valid & in_ready;
  assign rs       = bus.datars;
  assign rb       = bus.datarb;

  // Decode and single-cycle datapath.
  always_comb begin
    op_legal = (bus.po == PO_X);
    op_cnt   = 1'b0;
    op_res   = '0;
    unique case (bus.xo)
      XO_AND:    op_res = rs & rb;
      XO_ANDC:   op_res = rs & ~rb;
      XO_NOR:    op_res = ~(rs | rb);
      XO_EQV:    op_res = ~(rs ^ rb);
      XO_XOR:    op_res = rs ^ rb;
      XO_ORC:    op_res = rs | ~rb;
      XO_OR:     op_res = rs | rb;
      XO_NAND:   op_res = ~(rs & rb);
      XO_EXTSB:  op_res = {{(XLEN-8){rs[7]}}, rs[7:0]};
      XO_EXTSH:  op_res = {{(XLEN-16){rs[15]}}, rs[15:0]};
      XO_EXTSW:  op_res = {{(XLEN-32){rs[31]}}, rs[31:0]};
      XO_CNTLZD: op_cnt = 1'b1;
      default:   op_legal = 1'b0;
    endcase
  end

  // Shared chunk counter. In IDLE it looks at the incoming MSB chunk so chunk 0
  // is consumed at the accept edge; in CNT, rs_q is pre-shifted so the next
  // chunk always sits in the top 16 bits.
  logic [15:0] chunk;
  logic [4:0]  chunk_lz;
  logic [1:0]  chunk_idx;
  logic        prior_found;
  logic [6:0]  prior_cnt;
  logic [6:0]  cnt_upd;
  logic        found_upd;

  assign chunk       = (state_q == StIdle) ? rs[XLEN-1 -: 16] : rs_q[XLEN-1 -: 16];
  assign chunk_idx   = (state_q == StIdle) ? 2'd0 : k_q + 2'd1;
  assign prior_found = (state_q == StCnt) & found_q;
  assign prior_cnt   = (state_q == StCnt) ? cnt_q : 7'd64;
  assign found_upd   = prior_found | (chunk != '0);
  assign cnt_upd     = (!prior_found && chunk != '0) ?
                       7'({chunk_idx, 4'b0000}) + 7'(chunk_lz) : prior_cnt;

  lzc16 u_lzc16 (
    .data_i (chunk),
    .cnt_o  (chunk_lz)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    rs_d      = rs_q;
    cnt_d     = cnt_q;
    found_d   = found_q;
    ra_d      = ra_q;
    rc_d      = rc_q;
    so_d      = so_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    cr0_we_d  = 1'b0;
    cr0_d     = cr0_q;
    illegal_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (!op_legal) begin
            illegal_d = 1'b1;
          end else if (op_cnt) begin
            state_d = StCnt;
            k_d     = 2'd0;
            rs_d    = rs << 16;
            cnt_d   = cnt_upd;
            found_d = found_upd;
            ra_d    = bus.ra;
            rc_d    = bus.rc;
            so_d    = bus.xer_so;
          end else begin
            wb_en_d   = 1'b1;
            wb_addr_d = bus.ra;
            wb_data_d = op_res;
            if (bus.rc) begin
              cr0_we_d = 1'b1;
              cr0_d    = cr0_of(op_res, bus.xer_so);
            end
          end
        end
      end
      StCnt: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = StIdle;
        end else begin
          rs_d    = rs_q << 16;
          cnt_d   = cnt_upd;
          found_d = found_upd;
          // Last chunk: publish in the final busy cycle.
          if (k_q == 2'd2) begin
            wb_en_d   = 1'b1;
            wb_addr_d = ra_q;
            wb_data_d = XLEN'(cnt_upd);
            if (rc_q) begin
              cr0_we_d = 1'b1;
              cr0_d    = cr0_of(XLEN'(cnt_upd), so_q);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      k_q       <= '0;
      rs_q      <= '0;
      cnt_q     <= '0;
      found_q   <= 1'b0;
      ra_q      <= '0;
      rc_q      <= 1'b0;
      so_q      <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      cr0_we_q  <= 1'b0;
      cr0_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      rs_q      <= rs_d;
      cnt_q     <= cnt_d;
      found_q   <= found_d;
      ra_q      <= ra_d;
      rc_q      <= rc_d;
      so_q      <= so_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      cr0_we_q  <= cr0_we_d;
      cr0_q     <= cr0_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.busy     = (state_q == StCnt);
  assign bus.wb_en    = wb_en_q;
  assign bus.wb_addr  = wb_addr_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.cr0_we   = cr0_we_q;
  assign bus.cr0      = cr0_q;
  assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_x_exec_wb.sv
// Self-checking bench for x_exec_wb: directed vector table, random ops checked
// against a behavioural model, and hand sequences for back-to-back issue,
// hold-while-busy and reset in the middle of cntlzd.
module tb_x_exec_wb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  x_exec_wb_if #(.XLEN(64)) bus ();

  x_exec_wb #(
    .XLEN (64),
    .PO_X (6'd31)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0]  po;
    logic [8:0]  xo;
    logic        rc;
    logic [4:0]  ra;
    logic [63:0] rs;
    logic [63:0] rb;
    logic        so;
    bit          ill;
    bit          cnt;
    logic [63:0] data;
    logic [3:0]  cr0;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Architectural state the stage should be holding.
  logic [63:0] m_data;
  logic [4:0]  m_addr;
  logic [3:0]  m_cr0;

  vec_t        tbl[12];
  logic [8:0]  xo_list[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: what an X-form instruction computes, straight from the opcode list.
  function automatic void ref_exec(input logic [5:0] po, input logic [8:0] xo,
                                   input logic [63:0] rs, input logic [63:0] rb,
                                   output bit ill, output bit cnt, output logic [63:0] res);
    ill = 1'b0;
    cnt = 1'b0;
    res = '0;
    if (po != 6'd31) begin
      ill = 1'b1;
      return;
    end
    case (xo)
      9'd28:  res = rs & rb;
      9'd60:  res = rs & ~rb;
      9'd124: res = ~(rs | rb);
      9'd284: res = ~(rs ^ rb);
      9'd316: res = rs ^ rb;
      9'd412: res = rs | ~rb;
      9'd444: res = rs | rb;
      9'd476: res = ~(rs & rb);
      9'd442: res = 64'($signed(rs[7:0]));
      9'd410: res = 64'($signed(rs[15:0]));
      9'd474: res = 64'($signed(rs[31:0]));
      9'd58: begin
        cnt = 1'b1;
        res = 64'd64;
        for (int b = 63; b >= 0; b--) begin
          if (rs[b]) begin
            res = 64'(63 - b);
            break;
          end
        end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] ref_cr0(input logic [63:0] res, input logic so);
    logic lt, gt, eq;
    lt = ($signed(res) < 0);
    eq = (res == 64'd0);
    gt = !lt && !eq;
    return {lt, gt, eq, so};
  endfunction

  task automatic drive(input vec_t v);
    bus.po     = v.po;
    bus.xo     = v.xo;
    bus.rc     = v.rc;
    bus.ra     = v.ra;
    bus.datars = v.rs;
    bus.datarb = v.rb;
    bus.xer_so = v.so;
  endtask

  // Issue one instruction and observe six cycles of outputs.
  task automatic run_op(input vec_t v);
    int wb_n, wb_lat, cr_n, cr_lat, ill_n, ill_lat, nrdy, nbusy, exp_busy;
    logic [63:0] d;
    logic [4:0]  a;
    logic [3:0]  c;
    wb_n = 0; wb_lat = -1; cr_n = 0; cr_lat = -1; ill_n = 0; ill_lat = -1;
    nrdy = 0; nbusy = 0; d = '0; a = '0; c = '0;
    @(negedge clk);
    check("ready_at_issue", 64'(bus.in_ready), 64'd1);
    drive(v);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (bus.wb_en)     begin wb_n++;  wb_lat = cyc;  d = bus.wb_data; a = bus.wb_addr; end
      if (bus.cr0_we)    begin cr_n++;  cr_lat = cyc;  c = bus.cr0; end
      if (bus.illegal)   begin ill_n++; ill_lat = cyc; end
      if (!bus.in_ready) nrdy++;
      if (bus.busy)      nbusy++;
    end
    exp_busy = (!v.ill && v.cnt) ? 4 : 0;
    if (v.ill) begin
      check("illegal_pulses", 64'(ill_n), 64'd1);
      check("illegal_latency", 64'(ill_lat), 64'd1);
      check("wb_on_illegal", 64'(wb_n), 64'd0);
      check("cr0we_on_illegal", 64'(cr_n), 64'd0);
    end else begin
      check("wb_pulses", 64'(wb_n), 64'd1);
      check("wb_latency", 64'(wb_lat), v.cnt ? 64'd4 : 64'd1);
      check("wb_addr", 64'(a), 64'(v.ra));
      check("wb_data", d, v.data);
      check("cr0we_pulses", 64'(cr_n), 64'(v.rc));
      check("illegal_on_legal", 64'(ill_n), 64'd0);
      if (v.rc) begin
        check("cr0_latency", 64'(cr_lat), 64'(wb_lat));
        check("cr0_value", 64'(c), 64'(v.cr0));
      end
      m_data = v.data;
      m_addr = v.ra;
      if (v.rc) m_cr0 = v.cr0;
    end
    check("in_ready_low_cycles", 64'(nrdy), 64'(exp_busy));
    check("busy_cycles", 64'(nbusy), 64'(exp_busy));
    check("wb_data_hold", bus.wb_data, m_data);
    check("wb_addr_hold", 64'(bus.wb_addr), 64'(m_addr));
    check("cr0_hold", 64'(bus.cr0), 64'(m_cr0));
  endtask

  initial begin
    vec_t rv, va, vb;
    int   p1, p2, pulses;
    logic [63:0] d1, d2;
    logic [4:0]  a1, a2;
    bit   drop;

    xo_list = '{9'd28, 9'd60, 9'd124, 9'd284, 9'd316, 9'd412,
                9'd444, 9'd476, 9'd442, 9'd410, 9'd474, 9'd58};

    //           po     xo      rc    ra     rs                      rb                     so    ill   cnt   data                    cr0
    tbl[0]  = '{6'd31, 9'd28,  1'b0, 5'd7,  64'hF0F0,               64'h0FF0,              1'b0, 1'b0, 1'b0, 64'h00F0,               4'b0000};
    tbl[1]  = '{6'd31, 9'd476, 1'b1, 5'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'h0,                4'b0011};
    tbl[2]  = '{6'd31, 9'd58,  1'b0, 5'd3,  64'h0000_0000_0001_0000, 64'h0,               1'b0, 1'b0, 1'b1, 64'd47,                 4'b0000};
    tbl[3]  = '{6'd31, 9'd58,  1'b1, 5'd4,  64'h0,                  64'h0,                 1'b0, 1'b0, 1'b1, 64'd64,                 4'b0100};
    tbl[4]  = '{6'd31, 9'd474, 1'b1, 5'd5,  64'h0000_0000_8000_0001, 64'h0,               1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_8000_0001, 4'b1000};
    tbl[5]  = '{6'd30, 9'd28,  1'b1, 5'd6,  64'h1,                  64'h1,                 1'b0, 1'b1, 1'b0, 64'h0,                  4'b0000};
    tbl[6]  = '{6'd31, 9'd1,   1'b1, 5'd8,  64'h1,                  64'h1,                 1'b0, 1'b1, 1'b0, 64'h0,                  4'b0000};
    tbl[7]  = '{6'd31, 9'd442, 1'b1, 5'd9,  64'h80,                 64'h0,                 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 4'b1000};
    tbl[8]  = '{6'd31, 9'd444, 1'b1, 5'd10, 64'h0,                  64'h0,                 1'b1, 1'b0, 1'b0, 64'h0,                  4'b0011};
    tbl[9]  = '{6'd31, 9'd58,  1'b1, 5'd11, 64'h8000_0000_0000_0000, 64'h0,               1'b0, 1'b0, 1'b1, 64'd0,                  4'b0011};
    tbl[10] = '{6'd31, 9'd410, 1'b0, 5'd12, 64'h1234_7FFF,          64'h0,                 1'b0, 1'b0, 1'b0, 64'h7FFF,               4'b0000};
    tbl[11] = '{6'd31, 9'd58,  1'b1, 5'd31, 64'h1,                  64'h0,                 1'b1, 1'b0, 1'b1, 64'd63,                 4'b0101};
    // tbl[9]: count 0 -> EQ, xer_so 0 gives 4'b0010.
    tbl[9].cr0 = 4'b0010;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.po = '0; bus.xo = '0; bus.rc = 1'b0; bus.ra = '0;
    bus.datars = '0; bus.datarb = '0; bus.xer_so = 1'b0;
    m_data = '0; m_addr = '0; m_cr0 = '0;

    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_wb_en", 64'(bus.wb_en), 64'd0);
    check("rst_wb_data", bus.wb_data, 64'd0);
    check("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
    check("rst_cr0_we", 64'(bus.cr0_we), 64'd0);
    check("rst_cr0", 64'(bus.cr0), 64'd0);
    check("rst_illegal", 64'(bus.illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op(tbl[i]);

    // Random ops against the reference model.
    for (int i = 0; i < 200; i++) begin
      rv.po = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'd31;
      rv.xo = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511))
                                          : xo_list[$urandom_range(0, 11)];
      rv.rc = 1'($urandom_range(0, 1));
      rv.ra = 5'($urandom_range(0, 31));
      rv.rs = {$urandom(), $urandom()} >> $urandom_range(0, 64);
      rv.rb = {$urandom(), $urandom()};
      rv.so = 1'($urandom_range(0, 1));
      ref_exec(rv.po, rv.xo, rv.rs, rv.rb, rv.ill, rv.cnt, rv.data);
      rv.cr0 = ref_cr0(rv.data, rv.so);
      run_op(rv);
    end

    // Back-to-back OR then XOR: one write per cycle.
    va = '{6'd31, 9'd444, 1'b0, 5'd10, 64'h00FF_0000_0000_1234, 64'h0F00_0000_0000_4321,
           1'b0, 1'b0, 1'b0, 64'h0FFF_0000_0000_5335, 4'b0000};
    vb = va;
    vb.xo = 9'd316; vb.ra = 5'd11; vb.data = 64'h0FFF_0000_0000_5115;
    @(negedge clk);
    drive(va);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 drive(vb);
    @(negedge clk);
    check("b2b_first_wb_en", 64'(bus.wb_en), 64'd1);
    check("b2b_first_data", bus.wb_data, va.data);
    check("b2b_first_addr", 64'(bus.wb_addr), 64'(va.ra));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_second_wb_en", 64'(bus.wb_en), 64'd1);
    check("b2b_second_data", bus.wb_data, vb.data);
    check("b2b_second_addr", 64'(bus.wb_addr), 64'(vb.ra));
    @(negedge clk);
    check("b2b_quiet", 64'(bus.wb_en), 64'd0);
    m_data = vb.data; m_addr = vb.ra;

    // in_valid held through cntlzd: the AND waits until the stage is idle again.
    va = '{6'd31, 9'd58, 1'b0, 5'd12, 64'h100, 64'h0, 1'b0, 1'b0, 1'b1, 64'd55, 4'b0000};
    vb = '{6'd31, 9'd28, 1'b0, 5'd13, 64'hFF, 64'h0F, 1'b0, 1'b0, 1'b0, 64'h0F, 4'b0000};
    p1 = -1; p2 = -1; pulses = 0; d1 = '0; d2 = '0; a1 = '0; a2 = '0; drop = 1'b0;
    @(negedge clk);
    drive(va);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 drive(vb);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (bus.wb_en) begin
        pulses++;
        if (p1 < 0) begin p1 = cyc; d1 = bus.wb_data; a1 = bus.wb_addr; end
        else begin p2 = cyc; d2 = bus.wb_data; a2 = bus.wb_addr; end
      end
      drop = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1 if (drop) bus.in_valid = 1'b0;
    end
    check("hold_pulses", 64'(pulses), 64'd2);
    check("hold_cnt_cycle", 64'(p1), 64'd4);
    check("hold_cnt_data", d1, va.data);
    check("hold_cnt_addr", 64'(a1), 64'(va.ra));
    check("hold_and_cycle", 64'(p2), 64'd6);
    check("hold_and_data", d2, vb.data);
    check("hold_and_addr", 64'(a2), 64'(vb.ra));

    // Reset in the middle of cntlzd: immediate return to idle, no writeback.
    va = '{6'd31, 9'd58, 1'b1, 5'd20, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1, 64'd64, 4'b0101};
    @(negedge clk);
    drive(va);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midcnt_busy_before_rst", 64'(bus.busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midcnt_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midcnt_rst_busy", 64'(bus.busy), 64'd0);
    check("midcnt_rst_wb_en", 64'(bus.wb_en), 64'd0);
    check("midcnt_rst_wb_data", bus.wb_data, 64'd0);
    check("midcnt_rst_cr0", 64'(bus.cr0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (bus.wb_en || bus.cr0_we) pulses++;
    end
    check("midcnt_no_wb_after_rst", 64'(pulses), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/x_exec_wb.md
Name: x_exec_wb

Overview:
- Execute/writeback stage directly downstream of the X-format register-read stage (X_Format).
- Consumes decoded fields (PO, XO, Rc, ra) plus operands datars/datarb; computes the X-form logical/count/extend result.
- Drives the register-file write port for RA and the CR0 field when Rc=1.
- Handles single-cycle ops with latency 1; cntlzd runs through a fixed 4-cycle FSM, with valid/ready back-pressure.

Parameters:
- XLEN, 64, operand/result width (only 64 supported)
- PO_X, 6'd31, primary opcode accepted as X-form

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction + operands present
- in_ready  out  1  stage can accept this cycle
- po  in  6  primary opcode
- xo  in  9  extended opcode
- rc  in  1  record bit (update CR0)
- ra  in  5  destination register index
- datars  in  64  RS operand
- datarb  in  64  RB operand
- xer_so  in  1  XER summary-overflow, copied into CR0[0]
- wb_en  out  1  register-file write strobe, one cycle
- wb_addr  out  5  write index (= latched ra)
- wb_data  out  64  result
- cr0_we  out  1  CR0 write strobe, one cycle
- cr0  out  4  {LT,GT,EQ,SO}
- illegal  out  1  one-cycle pulse: unsupported po/xo accepted
- busy  out  1  high while in CNT state

Behaviour:
- Reset, async on rst_n=0: state=IDLE, all outputs 0 except in_ready=1. Reset mid-CNT aborts; no writeback.
- Accept = in_valid & in_ready. in_ready = (state==IDLE).
- XO decode, 9-bit, valid only with po==PO_X:
  - AND=28: rs&rb
  - ANDC=60: rs&~rb
  - NOR=124: ~(rs|rb)
  - EQV=284: ~(rs^rb)
  - XOR=316: rs^rb
  - ORC=412: rs|~rb
  - OR=444: rs|rb
  - NAND=476: ~(rs&rb)
  - EXTSB=442: sign-extend rs[7:0]
  - EXTSH=410: sign-extend rs[15:0]
  - EXTSW=474: sign-extend rs[31:0]
  - CNTLZD=58: count leading zeros of rs
- Single-cycle ops: result registered at accept edge. wb_en=1, wb_addr=ra, wb_data=result in the cycle after accept (latency 1). Back-to-back accepts give one write per cycle.
- CNTLZD FSM: IDLE -> CNT on accept; CNT holds 2-bit chunk counter k=0..3.
  - Chunk k = rs[63-16k -: 16], examined MSB chunk first.
  - First nonzero chunk latches count = 16k + lzc16(chunk); later chunks are ignored.
  - All four chunks zero gives count = 64.
  - CNT -> IDLE when k==3. wb_en pulses exactly 4 cycles after accept. in_ready=0 and busy=1 for those 4 cycles.
- CR0, when rc=1 on a legal op, is updated in the same cycle as wb_en:
  - LT = result[63]
  - GT = ~result[63] & |result
  - EQ = ~|result
  - SO = xer_so as sampled at accept
  - cr0_we pulses 1 cycle. When rc=0, cr0_we stays 0 and cr0 holds its value.
- Illegal (po!=PO_X, or unknown xo): illegal pulses 1 cycle after accept; no wb_en, no cr0_we; state unchanged.
- in_valid while in_ready=0 is not consumed; the upstream stage must hold its fields stable.
- wb_en, cr0_we and illegal return to 0 the cycle after their pulse; wb_data/wb_addr hold their last values.

Decomposition:
- Package x_exec_pkg holds:
  - PO_X and all XO_* 9-bit localparams
  - state enum {IDLE, CNT}
  - CR0 bit-position constants
- One sub-module: lzc16, a combinational 16-bit leading-zero counter (5-bit out, 16 for zero), instantiated once and time-shared across chunks.

Test Plan:
- Reset: rst_n=0 mid-CNT -> all outputs 0, in_ready=1 immediately (async); no wb_en after release.
- AND, ra=7, rs=64'hF0F0, rb=64'h0FF0, rc=0 -> next cycle wb_en=1, wb_addr=7, wb_data=64'h00F0, cr0_we=0.
- NAND, rs=rb=64'hFFFF_FFFF_FFFF_FFFF, rc=1, xer_so=1 -> wb_data=0, cr0=4'b0011, cr0_we=1.
- CNTLZD rs=64'h0000_0000_0001_0000, ra=3 -> in_ready=0 for 4 cycles, wb_en on cycle 4 with wb_data=47; CNTLZD rs=0 -> wb_data=64.
- EXTSW rs=64'h0000_0000_8000_0001, rc=1 -> wb_data=64'hFFFF_FFFF_8000_0001, cr0=4'b1000 (xer_so=0).
- po=6'd30 or xo=9'd1 -> illegal pulse next cycle, no wb_en. Back-to-back OR then XOR accepted on consecutive cycles -> two consecutive wb_en pulses with correct data.
